// File: rtl/manette_colonnes.sv
// manette_colonnes -- player column selector for the falling-brick game.
//
// Two raw push-buttons are synchronised (2 flops each), debounced and
// auto-repeated. Each accepted attempt tries to move the active column one
// step right (plus) or left (minus). A move is taken only when the target
// column's stack height is strictly below the current falling row.
//
// Optional feature: define MANETTE_WRAP_EN to let moves wrap from the last
// column to column 0 and from column 0 to the last column. Without it,
// out-of-range attempts are refused.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   boutonPlus   raw right button, active-high, asynchronous
//   boutonMoins  raw left button, active-high, asynchronous
//   hauteurs     packed column heights, column k at [k*HAUT_W +: HAUT_W]
//   row          current row of the falling brick
//   Col          active column index
//   move_ok      one-cycle pulse: an attempt moved Col
//   move_blocked one-cycle pulse: an attempt was refused
//   fsm_state    controller state, for debug and checkers
//
// Request semantics: a request is valid only while exactly one synchronised
// button is high; both-high and both-low are treated as "no request".
module manette_colonnes #(
  parameter int NB_COL     = 3,
  parameter int HAUT_W     = 3,
  parameter int INIT_COL   = 0,
  parameter int DEB_CYC    = 50000,
  parameter int REPEAT_DLY = 25000000,
  parameter int REPEAT_PER = 6250000,
  localparam int COL_W     = ($clog2(NB_COL) > 1) ? $clog2(NB_COL) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     boutonPlus,
  input  logic                     boutonMoins,
  input  logic [NB_COL*HAUT_W-1:0] hauteurs,
  input  logic [HAUT_W-1:0]        row,
  output logic [COL_W-1:0]         Col,
  output logic                     move_ok,
  output logic                     move_blocked,
  output logic [2:0]               fsm_state
);

`ifdef MANETTE_WRAP_EN
  localparam logic WRAP = 1'b1;
`else
  localparam logic WRAP = 1'b0;
`endif

  localparam int CNT_MAX_A = (DEB_CYC > REPEAT_DLY) ? DEB_CYC : REPEAT_DLY;
  localparam int CNT_MAX   = (CNT_MAX_A > REPEAT_PER) ? CNT_MAX_A : REPEAT_PER;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  // Counters run down to zero; loading N-1 gives exactly N state cycles.
  localparam logic [CNT_W-1:0] DEB_LOAD = CNT_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] DLY_LOAD = CNT_W'(REPEAT_DLY - 1);
  localparam logic [CNT_W-1:0] PER_LOAD = CNT_W'(REPEAT_PER - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NB_COL - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DEBOUNCE, S_HOLD, S_REPEAT, S_WAIT
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              dir, dir_nxt;     // 1 = plus, 0 = minus
  logic              attempt;
  logic              plus_s1, p, minus_s1, m;
  logic              req_p, req_m, req_dir;
  logic [COL_W-1:0]  tgt;
  logic              in_range;
  logic [HAUT_W-1:0] h_tgt;
  logic              allowed;

  assign fsm_state = state;

  // Button synchronisers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      plus_s1  <= 1'b0;
      p        <= 1'b0;
      minus_s1 <= 1'b0;
      m        <= 1'b0;
    end else begin
      plus_s1  <= boutonPlus;
      p        <= plus_s1;
      minus_s1 <= boutonMoins;
      m        <= minus_s1;
    end
  end

  assign req_p   = p & ~m;
  assign req_m   = m & ~p;
  assign req_dir = dir ? req_p : req_m;

  // Next state, counter and attempt strobe.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dir_nxt   = dir;
    attempt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_p || req_m) begin
          cnt_nxt   = DEB_LOAD;
          dir_nxt   = req_p;
          state_nxt = S_DEBOUNCE;
        end
      end
      S_DEBOUNCE: begin
        if (!req_dir) begin
          state_nxt = S_IDLE;
        end else if (cnt == '0) begin
          attempt   = 1'b1;
          cnt_nxt   = DLY_LOAD;
          state_nxt = S_HOLD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_HOLD, S_REPEAT: begin
        if (!req_dir) begin
          state_nxt = S_WAIT;
        end else if (cnt == '0) begin
          attempt   = 1'b1;
          cnt_nxt   = PER_LOAD;
          state_nxt = S_REPEAT;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_WAIT: begin
        // Only a full release re-arms the controller.
        if (!p && !m) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Target column for the latched direction, with range/wrap handling.
  always_comb begin
    tgt      = Col;
    in_range = 1'b1;
    if (dir) begin
      if (Col == LAST_COL) begin
        tgt      = '0;
        in_range = WRAP;
      end else begin
        tgt = Col + COL_W'(1);
      end
    end else begin
      if (Col == '0) begin
        tgt      = LAST_COL;
        in_range = WRAP;
      end else begin
        tgt = Col - COL_W'(1);
      end
    end
  end

  // Height of the target column; mux avoids indexing past the packed vector.
  always_comb begin
    h_tgt = '0;
    for (int k = 0; k < NB_COL; k++) begin
      if (tgt == k[COL_W-1:0]) h_tgt = hauteurs[k*HAUT_W +: HAUT_W];
    end
  end

  assign allowed = in_range && (h_tgt < row);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      dir          <= 1'b0;
      Col          <= COL_W'(INIT_COL);
      move_ok      <= 1'b0;
      move_blocked <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      dir          <= dir_nxt;
      move_ok      <= attempt & allowed;
      move_blocked <= attempt & ~allowed;
      if (attempt && allowed) Col <= tgt;
    end
  end

endmodule

// File: tb/tb_manette_colonnes.sv
// Testbench for manette_colonnes: randomized button presses against a
// press-level reference model, checked by a scoreboard queue and a monitor.
module tb_manette_colonnes;
  localparam int NB_COL = 3;
  localparam int HAUT_W = 3;
  localparam int INIT   = 0;
  localparam int DEB    = 4;
  localparam int DLY    = 20;
  localparam int PER    = 8;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bp = 1'b0;
  logic       bm = 1'b0;
  logic [8:0] hauteurs;
  logic [2:0] row;
  logic [1:0] col;
  logic       ok, blk;
  logic [2:0] fsm_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  manette_colonnes #(
    .NB_COL(NB_COL), .HAUT_W(HAUT_W), .INIT_COL(INIT),
    .DEB_CYC(DEB), .REPEAT_DLY(DLY), .REPEAT_PER(PER)
  ) dut (
    .clk(clk), .reset(rst_n), .boutonPlus(bp), .boutonMoins(bm),
    .hauteurs(hauteurs), .row(row), .Col(col),
    .move_ok(ok), .move_blocked(blk), .fsm_state(fsm_state)
  );

  // ---------------- reference model ----------------
  int m_col;
  int m_h[3];
  int m_row;

  always_comb begin
    hauteurs = {3'(m_h[2]), 3'(m_h[1]), 3'(m_h[0])};
    row      = 3'(m_row);
  end

  // One attempt in the model: returns {moved, column after attempt}.
  function automatic logic [2:0] model_attempt(bit plus);
    int t;
    bit inr;
    t   = plus ? m_col + 1 : m_col - 1;
    inr = (t >= 0) && (t < NB_COL);
`ifdef MANETTE_WRAP_EN
    if (!inr) begin
      t   = (t < 0) ? NB_COL - 1 : 0;
      inr = 1'b1;
    end
`endif
    if (inr && (m_h[t] < m_row)) begin
      m_col = t;
      return {1'b1, 2'(m_col)};
    end
    return {1'b0, 2'(m_col)};
  endfunction

  // ---------------- scoreboard ----------------
  // Entry: {edge number, moved, column}
  logic [34:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  function automatic void push(int c, logic [2:0] r);
    exp_q.push_back({32'(c), r});
  endfunction

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every pulse must match the head of the expected queue.
  logic [34:0] ent;
  always @(negedge clk) begin
    if (rst_n) begin
      if (ok && blk) begin
        n_cmp++;
        n_fail++;
        $display("FAIL both_pulses: move_ok and move_blocked high at edge %0d", cyc);
      end
      if (ok || blk) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pulse: ok=%0d blk=%0d col=%0d at edge %0d, none expected",
                   ok, blk, col, cyc);
        end else begin
          ent = exp_q.pop_front();
          if (int'(ent[34:3]) != cyc || ent[2] != ok || ent[1:0] != col) begin
            n_fail++;
            $display("FAIL pulse: edge %0d ok %0d col %0d, expected edge %0d ok %0d col %0d",
                     cyc, ok, col, ent[34:3], ent[2], ent[1:0]);
          end
        end
      end
    end
    if (exp_q.size() > 0 && int'(exp_q[0][34:3]) < cyc) begin
      ent = exp_q.pop_front();
      n_cmp++;
      n_fail++;
      $display("FAIL missing_pulse: no pulse seen, expected edge %0d ok %0d col %0d",
               ent[34:3], ent[2], ent[1:0]);
    end
  end

  // ---------------- driver tasks ----------------
  // Hold one button for len samples; attempts fall at +DEB+2, +DLY, then +PER
  // as long as the synchronised level is still high on that edge.
  task automatic press(bit plus, int len);
    int e;
    int off;
    int n;
    @(negedge clk);
    e   = cyc + 1;
    off = 2 + DEB;
    n   = 0;
    while (off <= len + 1) begin
      push(e + off, model_attempt(plus));
      off += (n == 0) ? DLY : PER;
      n++;
    end
    if (plus) bp = 1'b1;
    else      bm = 1'b1;
    repeat (len) @(negedge clk);
    bp = 1'b0;
    bm = 1'b0;
    repeat (4) @(negedge clk);
    check("col_after_press", int'(col), m_col);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bp    = 1'b0;
    bm    = 1'b0;
    m_col = INIT;
    #1;
    check("reset_col", int'(col), INIT);
    check("reset_ok", int'(ok), 0);
    check("reset_blk", int'(blk), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int e;
    m_col = INIT;
    m_h[0] = 0; m_h[1] = 0; m_h[2] = 0;
    m_row = 5;

    #1;
    check("por_col", int'(col), INIT);
    check("por_ok", int'(ok), 0);
    check("por_blk", int'(blk), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Short press: no attempt. Longer press: one move.
    press(1'b1, 3);
    press(1'b1, 10);

    // Height rule at the target column.
    m_h[2] = 5;
    press(1'b1, 10);
    m_h[2] = 4;
    press(1'b1, 10);

    // Auto-repeat from column 0 across the right edge.
    do_reset();
    m_h[2] = 0;
    press(1'b1, 40);

    // Both buttons suppress attempts until a full release.
    do_reset();
    @(negedge clk);
    e = cyc + 1;
    push(e + 2 + DEB, model_attempt(1'b1));
    bp = 1'b1;
    repeat (10) @(negedge clk);
    bm = 1'b1;
    repeat (10) @(negedge clk);
    bp = 1'b0;
    repeat (30) @(negedge clk);
    bm = 1'b0;
    repeat (3) @(negedge clk);
    check("col_after_both", int'(col), m_col);
    press(1'b0, 10);

    // Reset in the middle of a held press; button still held afterwards.
    @(negedge clk);
    e = cyc + 1;
    push(e + 2 + DEB, model_attempt(1'b1));
    bp = 1'b1;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    m_col = INIT;
    #1;
    check("midreset_col", int'(col), INIT);
    check("midreset_ok", int'(ok), 0);
    check("midreset_blk", int'(blk), 0);
    @(negedge clk);
    rst_n = 1'b1;
    e = cyc + 1;
    push(e + 2 + DEB, model_attempt(1'b1));
    repeat (10) @(negedge clk);
    bp = 1'b0;
    repeat (4) @(negedge clk);
    check("col_after_midreset", int'(col), m_col);

    // Randomized presses with random heights and row.
    for (int i = 0; i < 40; i++) begin
      m_row = $urandom_range(0, 7);
      for (int k = 0; k < NB_COL; k++) m_h[k] = $urandom_range(0, 7);
      press(1'($urandom_range(0, 1)), $urandom_range(1, 45));
    end

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
